// File: rtl/microarchtrace_encoder.sv
// microarchtrace_encoder
//   Classifies per-stage pipeline activity into trace events (SINGLE, START,
//   END, ABORT), packs them into records and buffers them in a multi-write
//   FIFO drained through a valid/ready stream.
//
//   Optional feature macro: MATRACE_TIMESTAMP_EN
//     defined   -> each record carries a TS_W-bit cycle timestamp in its LSBs
//     undefined -> no timestamp field, no counter
//
// Ports
//   clk          clock
//   rst_n        synchronous active-low reset
//   trace_en     record enable (multicycle tracking runs regardless)
//   stage_busy   per-stage: stage holds an instruction
//   stage_done   per-stage: stage completes its instruction
//   stage_flush  per-stage: stage contents killed
//   stage_pc     per-stage PC, stage s at [s*PC_W +: PC_W]
//   out_valid    record available
//   out_ready    sink accepts record
//   out_data     {lost, stage, kind, pc (, ts)}, MSB first
//   drop_cnt     saturating count of dropped events
//
// DEPTH must be a power of two, at least 2 and at least NUM_STAGES.
module microarchtrace_encoder #(
    parameter int NUM_STAGES = 4,
    parameter int PC_W       = 32,
    parameter int DEPTH      = 16,
    parameter int TS_W       = 32,
    localparam int SW        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
`ifdef MATRACE_TIMESTAMP_EN
    localparam int TS_FIELD_W = TS_W,
`else
    localparam int TS_FIELD_W = 0 * TS_W,
`endif
    localparam int REC_W     = 1 + SW + 2 + PC_W + TS_FIELD_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       trace_en,
    input  logic [NUM_STAGES-1:0]      stage_busy,
    input  logic [NUM_STAGES-1:0]      stage_done,
    input  logic [NUM_STAGES-1:0]      stage_flush,
    input  logic [NUM_STAGES*PC_W-1:0] stage_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [REC_W-1:0]           out_data,
    output logic [15:0]                drop_cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [1:0] K_SINGLE = 2'd0;
    localparam logic [1:0] K_START  = 2'd1;
    localparam logic [1:0] K_END    = 2'd2;
    localparam logic [1:0] K_ABORT  = 2'd3;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [CW-1:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + 17'(b);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    logic [REC_W-1:0]      mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic [NUM_STAGES-1:0] inflight, inflight_nxt, ev;
    logic [1:0]            kind [NUM_STAGES];
    logic [AW-1:0]         slot [NUM_STAGES];
    logic [REC_W-1:0]      rec  [NUM_STAGES];
    logic [CW-1:0]         n_ev, space;
    logic                  active, lost, do_write, do_drop, pop;

`ifdef MATRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts;

    always_ff @(posedge clk) begin
        if (!rst_n) ts <= '0;
        else        ts <= ts + 1'b1;
    end
`endif

    // Classification: the flush check comes first so a killed stage never
    // reports completion; inflight follows the pipeline even when tracing is
    // gated off, so records stay consistent once tracing resumes.
    always_comb begin
        inflight_nxt = inflight;
        ev           = '0;
        n_ev         = '0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            kind[s] = K_SINGLE;
            slot[s] = '0;
            if (stage_flush[s]) begin
                if (inflight[s]) begin
                    ev[s]           = 1'b1;
                    kind[s]         = K_ABORT;
                    inflight_nxt[s] = 1'b0;
                end
            end else if (stage_busy[s]) begin
                if (stage_done[s]) begin
                    ev[s]           = 1'b1;
                    kind[s]         = inflight[s] ? K_END : K_SINGLE;
                    inflight_nxt[s] = 1'b0;
                end else if (!inflight[s]) begin
                    ev[s]           = 1'b1;
                    kind[s]         = K_START;
                    inflight_nxt[s] = 1'b1;
                end
            end
            if (!(active && trace_en)) ev[s] = 1'b0;
            // Events pack densely in ascending stage order.
            slot[s] = n_ev[AW-1:0];
            if (ev[s]) n_ev = n_ev + 1'b1;
        end
    end

    // Only the first record of a successful write carries the lost marker.
    always_comb begin
        for (int s = 0; s < NUM_STAGES; s++) begin
            rec[s] = {(lost && (slot[s] == '0)), SW'(s), kind[s],
                      stage_pc[s*PC_W +: PC_W]
`ifdef MATRACE_TIMESTAMP_EN
                      , ts
`endif
                      };
        end
    end

    // Space is judged against the occupancy before this cycle's pop, so a
    // cycle's burst is all-or-nothing.
    assign space     = CW'(DEPTH) - count;
    assign do_write  = (n_ev != '0) && (n_ev <= space);
    assign do_drop   = (n_ev != '0) && (n_ev > space);
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            active   <= 1'b0;
            lost     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            active   <= 1'b1;
            inflight <= inflight_nxt;
            if (do_write) begin
                wr_ptr <= wr_ptr + n_ev[AW-1:0];
                lost   <= 1'b0;
            end
            if (do_drop) begin
                drop_cnt <= sat_add(drop_cnt, n_ev);
                lost     <= 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (do_write ? n_ev : '0) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                if (ev[s]) mem[wr_ptr + slot[s]] <= rec[s];
            end
        end
    end
endmodule

// File: tb/tb_microarchtrace_encoder.sv
// tb_microarchtrace_encoder
//   Directed stimulus for microarchtrace_encoder with hand-computed records.
module tb_microarchtrace_encoder;
    localparam int NS     = 4;
    localparam int PC_W   = 32;
    localparam int DEPTH  = 16;
    localparam int TS_W   = 32;
    localparam int SW     = 2;
`ifdef MATRACE_TIMESTAMP_EN
    localparam int REC_W  = 1 + SW + 2 + PC_W + TS_W;
`else
    localparam int REC_W  = 1 + SW + 2 + PC_W;
`endif
    localparam int BASE_W = 1 + SW + 2 + PC_W;

    logic               clk = 1'b0;
    logic               rst_n, trace_en, out_valid, out_ready;
    logic [NS-1:0]      busy, done, flush;
    logic [NS*PC_W-1:0] pc;
    logic [REC_W-1:0]   out_data;
    logic [15:0]        drop_cnt;
    int                 n_chk = 0;
    int                 n_pass = 0;

    microarchtrace_encoder #(
        .NUM_STAGES(NS), .PC_W(PC_W), .DEPTH(DEPTH), .TS_W(TS_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .trace_en(trace_en),
        .stage_busy(busy), .stage_done(done), .stage_flush(flush),
        .stage_pc(pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [BASE_W-1:0] rec(input logic l, input int s,
                                              input logic [1:0] k, input logic [31:0] p);
        return {l, SW'(s), k, p};
    endfunction

    task automatic idle();
        busy  = '0;
        done  = '0;
        flush = '0;
    endtask

    task automatic set_stage(input int s, input logic b, input logic d,
                             input logic f, input logic [31:0] p);
        busy[s]            = b;
        done[s]            = d;
        flush[s]           = f;
        pc[s*PC_W +: PC_W] = p;
    endtask

    task automatic expect_pop(input string tag, input logic [BASE_W-1:0] exp);
        chk({tag, "_vld"}, 64'(out_valid), 64'd1);
        chk(tag, 64'(out_data[REC_W-1 -: BASE_W]), 64'(exp));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; trace_en = 1'b0; out_ready = 1'b0; pc = '0;
        idle();
        tick(); tick();
        chk("rst_vld", 64'(out_valid), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);

        // First cycle after release is inactive: event must be ignored.
        rst_n = 1'b1; trace_en = 1'b1;
        set_stage(0, 1, 1, 0, 32'h999);
        tick(); idle();
        chk("inactive", 64'(out_valid), 64'd0);

        // T1 single-cycle
        set_stage(0, 1, 1, 0, 32'h100);
        tick(); idle();
        expect_pop("t1", rec(0, 0, 0, 32'h100));
        chk("t1_empty", 64'(out_valid), 64'd0);

        // trace_en low suppresses records
        trace_en = 1'b0;
        set_stage(0, 1, 1, 0, 32'h111);
        tick(); idle(); trace_en = 1'b1;
        chk("en_off", 64'(out_valid), 64'd0);

        // T2 multicycle: START, stall, END
        set_stage(1, 1, 0, 0, 32'h200);
        tick();
        chk("t2_first", 64'(out_data[REC_W-1 -: BASE_W]), 64'(rec(0, 1, 1, 32'h200)));
        tick();
        chk("t2_hold", 64'(out_data[REC_W-1 -: BASE_W]), 64'(rec(0, 1, 1, 32'h200)));
        set_stage(1, 1, 1, 0, 32'h200);
        tick(); idle();
        expect_pop("t2_start", rec(0, 1, 1, 32'h200));
        expect_pop("t2_end", rec(0, 1, 2, 32'h200));
        chk("t2_empty", 64'(out_valid), 64'd0);

        // T3 abort has priority over busy&done
        set_stage(2, 1, 0, 0, 32'h300);
        tick();
        set_stage(2, 1, 1, 1, 32'h300);
        tick();
        set_stage(2, 1, 1, 0, 32'h300);
        tick(); idle();
        expect_pop("t3_start", rec(0, 2, 1, 32'h300));
        expect_pop("t3_abort", rec(0, 2, 3, 32'h300));
        expect_pop("t3_single", rec(0, 2, 0, 32'h300));
        chk("t3_empty", 64'(out_valid), 64'd0);

        // T4 all stages in one cycle
        for (int s = 0; s < NS; s++) set_stage(s, 1, 1, 0, 32'((s + 1) * 16));
        tick(); idle();
        for (int s = 0; s < NS; s++) expect_pop($sformatf("t4_s%0d", s), rec(0, s, 0, 32'((s + 1) * 16)));
        chk("t4_empty", 64'(out_valid), 64'd0);

        // T5 fill to 14, atomic drop of a 4-event burst, then lost marker
        for (int c = 0; c < 4; c++) begin
            for (int s = 0; s < ((c < 3) ? 4 : 2); s++) set_stage(s, 1, 1, 0, 32'(c * 4 + s));
            tick(); idle();
        end
        for (int s = 0; s < NS; s++) set_stage(s, 1, 1, 0, 32'hAA);
        tick(); idle();
        chk("t5_drop", 64'(drop_cnt), 64'd4);
        set_stage(3, 1, 1, 0, 32'h77);
        tick(); idle();
        for (int i = 0; i < 14; i++) expect_pop($sformatf("t5_r%0d", i), rec(0, i % 4, 0, 32'(i)));
        expect_pop("t5_lost", rec(1, 3, 0, 32'h77));
        chk("t5_empty", 64'(out_valid), 64'd0);
        set_stage(0, 1, 1, 0, 32'h88);
        tick(); idle();
        expect_pop("t5_lost_clr", rec(0, 0, 0, 32'h88));

        // T6 reset mid-stream clears FIFO, drop count and inflight state
        set_stage(1, 1, 0, 0, 32'h500);
        tick(); idle();
        chk("t6_pre", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        tick();
        chk("t6_vld", 64'(out_valid), 64'd0);
        chk("t6_drop", 64'(drop_cnt), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        set_stage(1, 1, 1, 0, 32'h55);
        tick(); idle();
        chk("t6_rec", 64'(out_data[REC_W-1 -: BASE_W]), 64'(rec(0, 1, 0, 32'h55)));
`ifdef MATRACE_TIMESTAMP_EN
        chk("t6_ts", 64'(out_data[TS_W-1:0]), 64'd5);
`endif
        expect_pop("t6_pop", rec(0, 1, 0, 32'h55));
        chk("t6_empty", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
